// File: rtl/int2float_test_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | int2float_test_pkg                                                         |
// | Shared types, widths and helpers for the int2float response compactor.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package int2float_test_pkg;

    localparam int RESP_W = 7;
    localparam logic [RESP_W-1:0] DEFAULT_POLY = 7'h03;
    localparam logic [RESP_W-1:0] DEFAULT_SEED = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Response word ordering: {E[0],E[1],E[2],M[0],M[1],M[2],M[3]}, E[0] in the MSB
    function automatic logic [RESP_W-1:0] pack_resp(input logic [2:0] e, input logic [3:0] m);
        return {e[0], e[1], e[2], m[0], m[1], m[2], m[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/int2float_resp_compactor_misr_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | misr_step                                                                  |
// | Combinational one-step MISR update: shift, polynomial feedback, XOR data.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module misr_step #(
    parameter int                RESP_W = int2float_test_pkg::RESP_W,
    parameter logic [RESP_W-1:0] POLY   = int2float_test_pkg::DEFAULT_POLY
) (
    input  logic [RESP_W-1:0] sig,
    input  logic [RESP_W-1:0] data,
    output logic [RESP_W-1:0] next_sig
);

    logic [RESP_W-1:0] w_shift;
    logic [RESP_W-1:0] w_fb;

    assign w_shift  = {sig[RESP_W-2:0], 1'b0};
    assign w_fb     = sig[RESP_W-1] ? POLY : '0;
    assign next_sig = w_shift ^ w_fb ^ data;

endmodule
`default_nettype wire

// File: rtl/int2float_resp_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | int2float_resp_compactor                                                   |
// | Folds converter responses into a MISR and compares against a golden value. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module int2float_resp_compactor #(
    parameter int                RESP_W       = int2float_test_pkg::RESP_W,
    parameter int                SAMPLE_COUNT = 512,
    parameter logic [RESP_W-1:0] POLY         = int2float_test_pkg::DEFAULT_POLY,
    parameter logic [RESP_W-1:0] SEED         = int2float_test_pkg::DEFAULT_SEED,
    localparam int               CNT_W        = $clog2(SAMPLE_COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [RESP_W-1:0] in_data,
    input  logic [RESP_W-1:0] golden,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [RESP_W-1:0] signature,
    output logic [CNT_W-1:0]  sample_cnt
);

    import int2float_test_pkg::*;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SAMPLE_COUNT - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [RESP_W-1:0] r_sig;
    logic [RESP_W-1:0] w_sig_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pass;
    logic              w_accept;
    logic              w_restart;

    misr_step #(
        .RESP_W (RESP_W),
        .POLY   (POLY)
    ) u_misr (
        .sig      (r_sig),
        .data     (in_data),
        .next_sig (w_sig_next)
    );

    assign w_accept  = (r_state == ST_RUN) && in_valid;
    assign w_restart = (r_state == ST_DONE) && start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_RUN;
            ST_RUN:   if (in_valid && (r_cnt == C_LAST)) w_state_next = ST_CHECK;
            ST_CHECK: w_state_next = ST_DONE;
            ST_DONE:  if (start) w_state_next = ST_RUN;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Signature and count are held through CHECK/DONE until a restart reloads them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sig  <= SEED;
            r_cnt  <= '0;
            r_pass <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) || w_restart) begin
                r_sig <= SEED;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_sig <= w_sig_next;
                r_cnt <= r_cnt + C_ONE;
            end
            if (r_state == ST_CHECK) begin
                r_pass <= (r_sig == golden);
            end
        end
    end

    assign busy       = (r_state == ST_RUN) || (r_state == ST_CHECK);
    assign done       = (r_state == ST_DONE);
    assign pass       = r_pass;
    assign signature  = r_sig;
    assign sample_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_int2float_resp_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_int2float_resp_compactor                                                |
// | Scoreboard bench for the response compactor at SAMPLE_COUNT = 1, 2, 512.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_int2float_resp_compactor;

    import int2float_test_pkg::*;

    localparam logic [6:0] C_POLY = 7'h03;
    localparam logic [6:0] C_SEED = 7'h7F;
    localparam int         C_N    = 512;

    typedef struct {
        logic [6:0] sig;
        logic       pass;
        int         cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_v    [3];
    logic       in_valid_v [3];
    logic [6:0] in_data_v  [3];
    logic [6:0] golden_v   [3];
    logic       busy_v     [3];
    logic       done_v     [3];
    logic       pass_v     [3];
    logic [6:0] sig_v      [3];
    logic [0:0] r_cnt0;
    logic [1:0] r_cnt1;
    logic [9:0] r_cnt2;
    logic [9:0] cnt_v      [3];

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    always_comb begin
        cnt_v[0] = 10'(r_cnt0);
        cnt_v[1] = 10'(r_cnt1);
        cnt_v[2] = r_cnt2;
    end

    int2float_resp_compactor #(.SAMPLE_COUNT(1)) u_sc1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid_v[0]),
        .in_data(in_data_v[0]), .golden(golden_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .signature(sig_v[0]), .sample_cnt(r_cnt0)
    );
    int2float_resp_compactor #(.SAMPLE_COUNT(2)) u_sc2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid_v[1]),
        .in_data(in_data_v[1]), .golden(golden_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .signature(sig_v[1]), .sample_cnt(r_cnt1)
    );
    int2float_resp_compactor u_sc512 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid_v[2]),
        .in_data(in_data_v[2]), .golden(golden_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .signature(sig_v[2]), .sample_cnt(r_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] model_step(input logic [6:0] s, input logic [6:0] d);
        return ({s[5:0], 1'b0} ^ (s[6] ? C_POLY : 7'h00)) ^ d;
    endfunction

    // Three-phase converter pattern: all zeros, all ones, then alternating bits
    function automatic logic [6:0] pat(input int i);
        if (i < 171)       return pack_resp(3'b000, 4'b0000);
        else if (i < 342)  return pack_resp(3'b111, 4'b1111);
        else if (i % 2 == 0) return pack_resp(3'b101, 4'b0101);
        else               return pack_resp(3'b010, 4'b1010);
    endfunction

    function automatic logic [6:0] model_run(input logic faulty);
        logic [6:0] s = C_SEED;
        for (int i = 0; i < C_N; i++) s = model_step(s, pat(i) | {6'd0, faulty});
        return s;
    endfunction

    task automatic do_start(input int idx);
        start_v[idx] = 1'b1;
        tick();
        start_v[idx] = 1'b0;
    endtask

    task automatic send(input int idx, input logic [6:0] d);
        in_valid_v[idx] = 1'b1;
        in_data_v[idx]  = d;
        tick();
        in_valid_v[idx] = 1'b0;
    endtask

    task automatic push_exp(input logic [6:0] s, input logic p, input int c);
        exp_t e;
        e.sig = s; e.pass = p; e.cnt = c;
        exp_q.push_back(e);
    endtask

    task automatic finish_run(input int idx, input int budget);
        int   t = 0;
        exp_t e;
        while (done_v[idx] !== 1'b1 && t < budget) begin
            tick();
            t++;
        end
        check("done_within_budget", 32'(done_v[idx]), 32'd1);
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("final_signature", 32'(sig_v[idx]), 32'(e.sig));
            check("final_pass", 32'(pass_v[idx]), 32'(e.pass));
            check("final_count", 32'(cnt_v[idx]), 32'(e.cnt));
            check("busy_in_done", 32'(busy_v[idx]), 32'd0);
        end
    endtask

    initial begin
        logic [6:0] clean_sig;
        logic [6:0] fault_sig;
        logic [6:0] held_sig;

        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; in_valid_v[i] = 1'b0; in_data_v[i] = '0; golden_v[i] = '0;
        end
        clean_sig = model_run(1'b0);
        fault_sig = model_run(1'b1);
        check("pack_resp_order", 32'(pack_resp(3'b001, 4'b0001)), 32'h48);

        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("reset_busy", 32'(busy_v[i]), 32'd0);
            check("reset_done", 32'(done_v[i]), 32'd0);
            check("reset_pass", 32'(pass_v[i]), 32'd0);
            check("reset_signature", 32'(sig_v[i]), 32'(C_SEED));
            check("reset_count", 32'(cnt_v[i]), 32'd0);
        end

        // SAMPLE_COUNT=1: exactly one edge in CHECK before DONE
        golden_v[0] = 7'h7D;
        push_exp(7'h7D, 1'b1, 1);
        do_start(0);
        send(0, 7'h00);
        check("sc1_sig_after_sample", 32'(sig_v[0]), 32'h7D);
        check("sc1_done_in_check", 32'(done_v[0]), 32'd0);
        check("sc1_busy_in_check", 32'(busy_v[0]), 32'd1);
        finish_run(0, 1);

        // SAMPLE_COUNT=2 with a gap, then a failing golden on a restart from DONE
        golden_v[1] = 7'h79;
        push_exp(7'h79, 1'b1, 2);
        do_start(1);
        send(1, 7'h00);
        repeat (3) tick();
        check("sc2_gap_holds_count", 32'(cnt_v[1]), 32'd1);
        send(1, 7'h00);
        finish_run(1, 3);
        held_sig = sig_v[1];
        send(1, 7'h55);
        check("sc2_done_ignores_valid", 32'(sig_v[1]), 32'(held_sig));
        golden_v[1] = 7'h78;
        push_exp(7'h79, 1'b0, 2);
        do_start(1);
        check("sc2_restart_seed", 32'(sig_v[1]), 32'(C_SEED));
        send(1, 7'h00);
        send(1, 7'h00);
        finish_run(1, 3);

        // SAMPLE_COUNT=512 clean run: start+valid collision, start ignored in RUN
        golden_v[2] = clean_sig;
        push_exp(clean_sig, 1'b1, C_N);
        start_v[2] = 1'b1; in_valid_v[2] = 1'b1; in_data_v[2] = 7'h7F;
        tick();
        start_v[2] = 1'b0; in_valid_v[2] = 1'b0;
        check("collision_count", 32'(cnt_v[2]), 32'd0);
        check("collision_signature", 32'(sig_v[2]), 32'(C_SEED));
        for (int i = 0; i < 3; i++) send(2, pat(i));
        do_start(2);
        check("start_in_run_count", 32'(cnt_v[2]), 32'd3);
        send(2, pat(3));
        check("start_in_run_continues", 32'(cnt_v[2]), 32'd4);
        for (int i = 4; i < C_N; i++) send(2, pat(i));
        finish_run(2, 3);

        // Reset mid-run, then a full clean run
        do_start(2);
        for (int i = 0; i < 100; i++) send(2, pat(i));
        check("midrun_count", 32'(cnt_v[2]), 32'd100);
        rst_n = 1'b0;
        tick();
        check("midrun_reset_busy", 32'(busy_v[2]), 32'd0);
        check("midrun_reset_done", 32'(done_v[2]), 32'd0);
        check("midrun_reset_pass", 32'(pass_v[2]), 32'd0);
        check("midrun_reset_signature", 32'(sig_v[2]), 32'(C_SEED));
        check("midrun_reset_count", 32'(cnt_v[2]), 32'd0);
        rst_n = 1'b1;
        push_exp(clean_sig, 1'b1, C_N);
        do_start(2);
        for (int i = 0; i < C_N; i++) send(2, pat(i));
        finish_run(2, 3);

        // M[3] stuck-at-1 against the clean golden signature
        push_exp(fault_sig, (fault_sig == clean_sig), C_N);
        do_start(2);
        for (int i = 0; i < C_N; i++) send(2, pat(i) | 7'h01);
        finish_run(2, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
